// File: rtl/rst_seq_pkg.sv
// Shared constants and state encoding for the staged reset sequencer.
package rst_seq_pkg;

    localparam int unsigned STATE_W         = 2;
    localparam int unsigned DEF_HOLD_CYCLES = 1024;
    localparam int unsigned DEF_STAGES      = 3;
    localparam int unsigned DEF_STAGE_GAP   = 16;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_WDOG_CYCLES = 65535;

    typedef enum logic [STATE_W-1:0] {
        WAIT_OK = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rst_seq_if.sv
// Control/status bundle of the reset sequencer; wdog_err exists only with RST_SEQ_WDOG_EN.
interface rst_seq_if
    import rst_seq_pkg::*;
#(
    parameter int unsigned STAGES = DEF_STAGES
);
    logic               clk_ok;
    logic               sw_rst_req;
    logic [STAGES-1:0]  rst_out;
    logic               seq_done;
    logic [STATE_W-1:0] seq_state;
`ifdef RST_SEQ_WDOG_EN
    logic               wdog_err;
`endif

    modport master (
        output clk_ok,
        output sw_rst_req,
        input  rst_out,
        input  seq_done,
        input  seq_state
`ifdef RST_SEQ_WDOG_EN
        , input wdog_err
`endif
    );

    modport slave (
        input  clk_ok,
        input  sw_rst_req,
        output rst_out,
        output seq_done,
        output seq_state
`ifdef RST_SEQ_WDOG_EN
        , output wdog_err
`endif
    );

endinterface

// File: rtl/rst_seq_cnt.sv
// Clearable, loadable, saturating up-counter with a terminal-count compare.
module rst_seq_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_c_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over load, load over increment; increment stops at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == tc_val_i);

    // Callers never count past their terminal value, so saturation must never be hit.
    a_no_saturate: assert property (@(posedge clk) disable iff (reset)
        !(inc_i && !clr_i && !load_i && (&cnt_q)));

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: waits for a stable clock, holds off, then releases resets one stage
// at a time. Optional sticky watchdog on a stuck start-up enabled by RST_SEQ_WDOG_EN.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned STAGES      = DEF_STAGES,
    parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP,
    parameter int unsigned CNT_W       = DEF_CNT_W
`ifdef RST_SEQ_WDOG_EN
    , parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
`endif
) (
    input  logic     clk,
    input  logic     reset,
    rst_seq_if.slave bus
);

    localparam int unsigned IDX_W = 3;

    seq_state_e        state_q;
    logic [STAGES-1:0] rst_out_q;
    logic              seq_done_q;
    logic [IDX_W-1:0]  idx_q;

    logic              abort_c;
    logic              release_now_c;
    logic              cnt_clr_c;
    logic              cnt_inc_c;
    logic              cnt_tc_c;
    logic [CNT_W-1:0]  cnt_tc_val_c;

    // Loss of clock or a software request outside WAIT_OK collapses everything back to reset.
    assign abort_c       = (state_q != WAIT_OK) && (!bus.clk_ok || bus.sw_rst_req);
    assign release_now_c = (state_q == RELEASE) && ((idx_q == '0) || cnt_tc_c);
    assign cnt_tc_val_c  = (state_q == HOLD) ? CNT_W'(HOLD_CYCLES - 1)
                                             : CNT_W'(STAGE_GAP - 1);
    assign cnt_clr_c     = abort_c || (state_q == WAIT_OK) || (state_q == RUN)
                         || ((state_q == HOLD) && cnt_tc_c) || release_now_c;
    assign cnt_inc_c     = !cnt_clr_c && ((state_q == HOLD) || (state_q == RELEASE));

    rst_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr_c),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (cnt_inc_c),
        .tc_val_i   (cnt_tc_val_c),
        .tc_c_o     (cnt_tc_c)
    );

    always_ff @(posedge clk) begin
        if (reset || abort_c) begin
            state_q    <= WAIT_OK;
            rst_out_q  <= '1;
            seq_done_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            case (state_q)
                WAIT_OK: begin
                    if (bus.clk_ok) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_tc_c) begin
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (release_now_c) begin
                        rst_out_q <= rst_out_q & ~(STAGES'(1) << idx_q);
                        if (idx_q == IDX_W'(STAGES - 1)) begin
                            state_q    <= RUN;
                            seq_done_q <= 1'b1;
                            idx_q      <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= WAIT_OK;
                end
            endcase
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.seq_done  = seq_done_q;
    assign bus.seq_state = state_q;

`ifdef RST_SEQ_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic wdog_q;
    logic wdog_tc_c;
    logic wdog_pre_c;

    // Counts consecutive WAIT_OK/HOLD cycles; any progress to RELEASE restarts it.
    assign wdog_pre_c = (state_q == WAIT_OK) || (state_q == HOLD);

    rst_seq_cnt #(.W(WDOG_W)) u_wdog_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (bus.sw_rst_req || !wdog_pre_c),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (wdog_pre_c && !wdog_tc_c),
        .tc_val_i   (WDOG_W'(WDOG_CYCLES - 1)),
        .tc_c_o     (wdog_tc_c)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.sw_rst_req) begin
            wdog_q <= 1'b0;
        end else if (wdog_pre_c && wdog_tc_c) begin
            wdog_q <= 1'b1;
        end
    end

    assign bus.wdog_err = wdog_q;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: timing model driven by elapsed cycles plus directed literal checks.
// Watchdog checks are included when RST_SEQ_WDOG_EN is defined.
module tb_rst_seq;
    import rst_seq_pkg::*;

    localparam int unsigned H = 8;
    localparam int unsigned S = 3;
    localparam int unsigned G = 4;

    logic clk;
    logic reset;

    rst_seq_if #(.STAGES(S)) bus ();

    rst_seq #(
        .HOLD_CYCLES (H),
        .STAGES      (S),
        .STAGE_GAP   (G),
        .CNT_W       (8)
`ifdef RST_SEQ_WDOG_EN
        , .WDOG_CYCLES (20)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: idle, or active with m_e edges elapsed since the edge that first saw clk_ok high.
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;
    int m_e      = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_e      = 0;
        end else if (!m_active) begin
            if (bus.clk_ok) begin
                m_active = 1'b1;
                m_e      = 0;
            end
        end else if (!bus.clk_ok || bus.sw_rst_req) begin
            m_active = 1'b0;
        end else if (m_e < 100000) begin
            m_e++;
        end
    end

    function automatic int released(int e);
        int n;
        if (e < int'(H) + 1) return 0;
        n = 1 + (e - int'(H) - 1) / int'(G);
        if (n > int'(S)) n = int'(S);
        return n;
    endfunction

    always @(negedge clk) begin
        logic [S-1:0] e_rst;
        logic         e_done;
        logic [1:0]   e_state;
        int           n;
        if (m_valid) begin
            n       = m_active ? released(m_e) : 0;
            e_rst   = '1;
            e_rst   = e_rst << n;
            e_done  = m_active && (n == int'(S));
            if (!m_active)            e_state = 2'd0;
            else if (m_e < int'(H))   e_state = 2'd1;
            else if (n < int'(S))     e_state = 2'd2;
            else                      e_state = 2'd3;
            n_vec++;
            if (bus.rst_out !== e_rst || bus.seq_done !== e_done || bus.seq_state !== e_state) begin
                n_bad++;
                $display("FAIL model t=%0t: rst_out=%b seq_done=%b state=%0d, expected rst_out=%b seq_done=%b state=%0d",
                         $time, bus.rst_out, bus.seq_done, bus.seq_state, e_rst, e_done, e_state);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.clk_ok     = 1'b0;
        bus.sw_rst_req = 1'b0;
        wait_edges(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        bus.clk_ok     = 1'b0;
        bus.sw_rst_req = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_rst",   8'(bus.rst_out),   8'h7);
        chk("reset_done",  8'(bus.seq_done),  8'h0);
        chk("reset_state", 8'(bus.seq_state), 8'h0);

        // Full sequence with clk_ok held high
        bus.clk_ok = 1'b1;
        wait_edges(9);
        chk("c8_rst",    8'(bus.rst_out),   8'h7);
        chk("c8_state",  8'(bus.seq_state), 8'h2);
        wait_edges(1);
        chk("c9_rst",    8'(bus.rst_out),   8'h6);
        wait_edges(3);
        chk("c12_rst",   8'(bus.rst_out),   8'h6);
        wait_edges(1);
        chk("c13_rst",   8'(bus.rst_out),   8'h4);
        wait_edges(3);
        chk("c16_done",  8'(bus.seq_done),  8'h0);
        wait_edges(1);
        chk("c17_rst",   8'(bus.rst_out),   8'h0);
        chk("c17_done",  8'(bus.seq_done),  8'h1);
        chk("c17_state", 8'(bus.seq_state), 8'h3);

        // Software re-sequence from RUN
        bus.sw_rst_req = 1'b1;
        wait_edges(1);
        bus.sw_rst_req = 1'b0;
        chk("sw_rst",   8'(bus.rst_out),   8'h7);
        chk("sw_done",  8'(bus.seq_done),  8'h0);
        chk("sw_state", 8'(bus.seq_state), 8'h0);
        wait_edges(10);
        chk("reseq_c9_rst", 8'(bus.rst_out), 8'h6);
        wait_edges(8);
        chk("reseq_c17_rst",  8'(bus.rst_out),  8'h0);
        chk("reseq_c17_done", 8'(bus.seq_done), 8'h1);

        // Clock loss between stage releases
        bus.clk_ok = 1'b0;
        wait_edges(1);
        bus.clk_ok = 1'b1;
        wait_edges(15);
        chk("mid_rst", 8'(bus.rst_out), 8'h4);
        bus.clk_ok = 1'b0;
        wait_edges(1);
        chk("abort_rst",   8'(bus.rst_out),   8'h7);
        chk("abort_state", 8'(bus.seq_state), 8'h0);
        wait_edges(3);
        chk("abort_hold_rst", 8'(bus.rst_out), 8'h7);

        // Hold restarts after a one-cycle clk_ok drop
        bus.clk_ok = 1'b1;
        wait_edges(5);
        bus.clk_ok = 1'b0;
        wait_edges(1);
        chk("glitch_state", 8'(bus.seq_state), 8'h0);
        bus.clk_ok = 1'b1;
        wait_edges(9);
        chk("restart_c8_rst", 8'(bus.rst_out), 8'h7);
        wait_edges(1);
        chk("restart_c9_rst", 8'(bus.rst_out), 8'h6);

        // sw_rst_req coincident with clk_ok fall in RELEASE
        bus.clk_ok     = 1'b0;
        bus.sw_rst_req = 1'b1;
        wait_edges(1);
        chk("dual_state", 8'(bus.seq_state), 8'h0);
        chk("dual_rst",   8'(bus.rst_out),   8'h7);
        bus.clk_ok     = 1'b1;
        bus.sw_rst_req = 1'b0;
        wait_edges(1);
        chk("dual_next_state", 8'(bus.seq_state), 8'h1);
        bus.sw_rst_req = 1'b1;
        wait_edges(1);
        chk("sw_in_hold_state", 8'(bus.seq_state), 8'h0);
        bus.clk_ok = 1'b0;
        wait_edges(1);
        chk("sw_in_wait_ignored", 8'(bus.seq_state), 8'h0);
        bus.clk_ok = 1'b1;
        wait_edges(1);
        chk("sw_wait_to_hold", 8'(bus.seq_state), 8'h1);
        bus.sw_rst_req = 1'b0;

        // Synchronous reset while running
        wait_edges(20);
        chk("run_done", 8'(bus.seq_done), 8'h1);
        reset = 1'b1;
        wait_edges(1);
        chk("rst_run_rst",   8'(bus.rst_out),   8'h7);
        chk("rst_run_state", 8'(bus.seq_state), 8'h0);
        chk("rst_run_done",  8'(bus.seq_done),  8'h0);
        reset      = 1'b0;
        bus.clk_ok = 1'b0;

`ifdef RST_SEQ_WDOG_EN
        do_reset();
        chk("wdog_reset", 8'(bus.wdog_err), 8'h0);
        wait_edges(19);
        chk("wdog_c19", 8'(bus.wdog_err), 8'h0);
        wait_edges(1);
        chk("wdog_c20", 8'(bus.wdog_err), 8'h1);
        wait_edges(5);
        chk("wdog_sticky", 8'(bus.wdog_err), 8'h1);
        chk("wdog_rst_out", 8'(bus.rst_out), 8'h7);
        bus.sw_rst_req = 1'b1;
        wait_edges(1);
        bus.sw_rst_req = 1'b0;
        chk("wdog_sw_clear", 8'(bus.wdog_err), 8'h0);
`endif

        wait_edges(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
